// File: rtl/usb_tx_sequencer.sv
// USB packet transmit sequencer: SYNC, PID, payload, CRC16 and EOP control.
// Build option: define USB_TX_CRC_EN to append CRC_LO/CRC_HI to data packets.
module usb_tx_sequencer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [7:0] tx_pid,
  input  logic       tx_has_data,
  input  logic [6:0] tx_len,
  input  logic       fifo_empty,
  input  logic       Load_Byte,
  output logic [7:0] FSM_byte,
  output logic [1:0] select,
  output logic       load_en,
  output logic       idle,
  output logic       Tim_rst,
  output logic       Tim_en,
  output logic       eop,
  output logic       eop_new_bit,
  output logic       fifo_rd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  localparam logic [1:0] SEL_FIFO  = 2'd0;
  localparam logic [1:0] SEL_FSM   = 2'd1;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [6:0] MAX_LEN   = 7'd64;

`ifdef USB_TX_CRC_EN
  localparam logic [1:0] SEL_CRCL = 2'd2;
  localparam logic [1:0] SEL_CRCH = 2'd3;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SYNC,
    S_PID,
    S_DATA,
`ifdef USB_TX_CRC_EN
    S_CRC_LO,
    S_CRC_HI,
`endif
    S_EOP_SE0,
    S_EOP_J,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pid_q, pid_d;
  logic       data_q, data_d;
  logic [6:0] rem_q, rem_d;
  logic [2:0] div_q, div_d;
  logic       se0_q, se0_d;
  logic [1:0] sel_q, sel_d;
  logic [7:0] byte_q, byte_d;
  logic       urun_q, urun_d;

  logic [6:0] len_clamp;
  logic [1:0] tail_sel;
  logic [1:0] len0_sel;

  assign len_clamp = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;

`ifdef USB_TX_CRC_EN
  assign tail_sel = SEL_CRCL;
  assign len0_sel = SEL_CRCL;
`else
  assign tail_sel = SEL_FSM;
  assign len0_sel = SEL_FSM;
`endif

  assign select      = sel_q;
  assign FSM_byte    = byte_q;
  assign tx_underrun = urun_q;

  // Next-state, next-datapath and control output decode.
  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    data_d      = data_q;
    rem_d       = rem_q;
    div_d       = div_q;
    se0_d       = se0_q;
    sel_d       = sel_q;
    byte_d      = byte_q;
    urun_d      = urun_q;
    load_en     = 1'b0;
    idle        = 1'b0;
    Tim_rst     = 1'b0;
    Tim_en      = 1'b0;
    eop         = 1'b0;
    eop_new_bit = 1'b0;
    fifo_rd     = 1'b0;
    tx_busy     = 1'b1;
    tx_done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        idle    = 1'b1;
        tx_busy = 1'b0;
        if (tx_start) begin
          pid_d   = tx_pid;
          data_d  = tx_has_data;
          rem_d   = len_clamp;
          urun_d  = 1'b0;
          sel_d   = SEL_FSM;
          byte_d  = SYNC_BYTE;
          state_d = S_START;
        end
      end

      S_START: begin
        Tim_rst = 1'b1;
        load_en = 1'b1;
        byte_d  = pid_q;
        state_d = S_SYNC;
      end

      S_SYNC: begin
        Tim_en = 1'b1;
        if (Load_Byte) begin
          state_d = S_PID;
          if (data_q && rem_q != 7'd0)
            sel_d = SEL_FIFO;
          else if (data_q)
            sel_d = len0_sel;
          else
            sel_d = SEL_FSM;
        end
      end

      S_PID: begin
        Tim_en = 1'b1;
        if (Load_Byte) begin
          if (sel_q == SEL_FIFO) begin
            if (fifo_empty) begin
              urun_d  = 1'b1;
              state_d = S_EOP_SE0;
            end else begin
              fifo_rd = 1'b1;
              rem_d   = rem_q - 7'd1;
              state_d = S_DATA;
              if (rem_q == 7'd1)
                sel_d = tail_sel;
            end
          end else if (data_q) begin
`ifdef USB_TX_CRC_EN
            state_d = S_CRC_LO;
            sel_d   = SEL_CRCH;
`else
            state_d = S_EOP_SE0;
`endif
          end else begin
            state_d = S_EOP_SE0;
          end
        end
      end

      S_DATA: begin
        Tim_en = 1'b1;
        if (Load_Byte) begin
          if (sel_q == SEL_FIFO) begin
            if (fifo_empty) begin
              urun_d  = 1'b1;
              state_d = S_EOP_SE0;
            end else begin
              fifo_rd = 1'b1;
              rem_d   = rem_q - 7'd1;
              if (rem_q == 7'd1)
                sel_d = tail_sel;
            end
          end else begin
`ifdef USB_TX_CRC_EN
            state_d = S_CRC_LO;
            sel_d   = SEL_CRCH;
`else
            state_d = S_EOP_SE0;
`endif
          end
        end
      end

`ifdef USB_TX_CRC_EN
      S_CRC_LO: begin
        Tim_en = 1'b1;
        if (Load_Byte)
          state_d = S_CRC_HI;
      end

      S_CRC_HI: begin
        Tim_en = 1'b1;
        if (Load_Byte)
          state_d = S_EOP_SE0;
      end
`endif

      S_EOP_SE0: begin
        eop   = 1'b1;
        div_d = div_q + 3'd1;
        if (div_q == 3'd7) begin
          eop_new_bit = 1'b1;
          se0_d       = ~se0_q;
          if (se0_q)
            state_d = S_EOP_J;
        end
      end

      S_EOP_J: begin
        div_d = div_q + 3'd1;
        if (div_q == 3'd7) begin
          eop_new_bit = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        idle    = 1'b1;
        Tim_rst = 1'b1;
        tx_done = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_EOP_SE0 && state_q != S_EOP_SE0) begin
      sel_d  = SEL_FIFO;
      byte_d = 8'h00;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      pid_q   <= 8'h00;
      data_q  <= 1'b0;
      rem_q   <= 7'd0;
      div_q   <= 3'd0;
      se0_q   <= 1'b0;
      sel_q   <= SEL_FIFO;
      byte_q  <= 8'h00;
      urun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      se0_q   <= se0_d;
      sel_q   <= sel_d;
      byte_q  <= byte_d;
      urun_q  <= urun_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed testbench for usb_tx_sequencer.
// Transmitter modelled as a Load_Byte pulse every 3rd Tim_en cycle.
module tb_usb_tx_sequencer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [7:0] tx_pid;
  logic       tx_has_data;
  logic [6:0] tx_len;
  logic       fifo_empty;
  logic       Load_Byte;
  logic [7:0] FSM_byte;
  logic [1:0] select;
  logic       load_en;
  logic       idle;
  logic       Tim_rst;
  logic       Tim_en;
  logic       eop;
  logic       eop_new_bit;
  logic       fifo_rd;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_underrun;

  always #5 clk = ~clk;

  usb_tx_sequencer dut (
    .clk(clk),
    .n_rst(n_rst),
    .tx_start(tx_start),
    .tx_pid(tx_pid),
    .tx_has_data(tx_has_data),
    .tx_len(tx_len),
    .fifo_empty(fifo_empty),
    .Load_Byte(Load_Byte),
    .FSM_byte(FSM_byte),
    .select(select),
    .load_en(load_en),
    .idle(idle),
    .Tim_rst(Tim_rst),
    .Tim_en(Tim_en),
    .eop(eop),
    .eop_new_bit(eop_new_bit),
    .fifo_rd(fifo_rd),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_underrun(tx_underrun)
  );

`ifdef USB_TX_CRC_EN
  localparam int CRC_LB = 2;
`else
  localparam int CRC_LB = 0;
`endif

  int vec  = 0;
  int errs = 0;

  int m_lb, m_pops, m_stray, m_eop, m_j, m_nb;
  int m_done, m_busy, m_ovl, m_ld, m_last_lb;
  int m_first_eop, m_timeout, m_urun_start;
  logic [1:0] m_st_sel;
  logic [7:0] m_st_byte;
  logic [1:0] lb_sel[$];
  logic [7:0] lb_byte[$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic run_packet(
    input logic [7:0] pid,
    input logic       hd,
    input logic [6:0] len,
    input int         empty_after,
    input logic       hold
  );
    int ph, cyc;
    logic fin;
    m_lb = 0; m_pops = 0; m_stray = 0; m_eop = 0;
    m_j = 0; m_nb = 0; m_done = 0; m_busy = 0;
    m_ovl = 0; m_ld = 0; m_last_lb = -1;
    m_first_eop = -1; m_timeout = 0; m_urun_start = -1;
    m_st_sel = 2'bxx; m_st_byte = 8'hxx;
    lb_sel.delete();
    lb_byte.delete();
    tx_pid = pid;
    tx_has_data = hd;
    tx_len = len;
    fifo_empty = (empty_after == 0);
    tx_start = 1'b1;
    step();
    if (!hold) tx_start = 1'b0;
    ph = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 3000) begin
      Load_Byte = Tim_en && (ph == 2);
      fifo_empty = (m_pops >= empty_after);
      #1;
      if (cyc == 0) m_urun_start = int'(tx_underrun);
      if (load_en) begin
        m_ld++;
        m_st_sel = select;
        m_st_byte = FSM_byte;
      end
      if (Load_Byte) begin
        m_lb++;
        m_last_lb = cyc;
        lb_sel.push_back(select);
        lb_byte.push_back(FSM_byte);
      end
      if (fifo_rd) begin
        m_pops++;
        if (!Load_Byte) m_stray++;
      end
      if (eop) begin
        m_eop++;
        if (m_first_eop < 0) m_first_eop = cyc;
      end
      if (!eop && !idle && m_first_eop >= 0) m_j++;
      if (eop && Tim_en) m_ovl++;
      if (eop_new_bit) m_nb++;
      if (tx_busy) m_busy++;
      if (tx_done) begin
        m_done++;
        fin = 1'b1;
      end
      ph = Tim_en ? ((ph == 2) ? 0 : ph + 1) : 0;
      step();
      cyc++;
    end
    Load_Byte = 1'b0;
    m_timeout = fin ? 0 : 1;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tx_start = 1'b0;
    tx_pid = 8'h00;
    tx_has_data = 1'b0;
    tx_len = 7'd0;
    fifo_empty = 1'b0;
    Load_Byte = 1'b0;
    step();
    step();
    #1;
    vec++;
    if (idle !== 1'b1) begin
      errs++;
      $display("FAIL reset_idle: got %b want 1", idle);
    end
    vec++;
    if ({FSM_byte, select, load_en, Tim_rst, Tim_en, eop, eop_new_bit,
         fifo_rd, tx_busy, tx_done, tx_underrun} !== 19'd0) begin
      errs++;
      $display("FAIL reset_outputs: got %h want 0",
        {FSM_byte, select, load_en, Tim_rst, Tim_en, eop, eop_new_bit,
         fifo_rd, tx_busy, tx_done, tx_underrun});
    end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_handshake();
    run_packet(8'hD2, 1'b0, 7'd5, 1000, 1'b0);
    vec++;
    if (m_timeout != 0) begin errs++; $display("FAIL hs_timeout: got %0d want 0", m_timeout); end
    vec++;
    if (m_st_byte !== 8'h80 || m_st_sel !== 2'd1) begin
      errs++; $display("FAIL hs_sync: got %h/%0d want 80/1", m_st_byte, m_st_sel);
    end
    vec++;
    if (m_lb != 2) begin errs++; $display("FAIL hs_loads: got %0d want 2", m_lb); end
    vec++;
    if (lb_byte[0] !== 8'hD2 || lb_sel[0] !== 2'd1) begin
      errs++; $display("FAIL hs_pid: got %h/%0d want d2/1", lb_byte[0], lb_sel[0]);
    end
    vec++;
    if (m_pops != 0) begin errs++; $display("FAIL hs_fifo_rd: got %0d want 0", m_pops); end
    vec++;
    if (m_eop != 16) begin errs++; $display("FAIL hs_se0: got %0d want 16", m_eop); end
    vec++;
    if (m_j != 8) begin errs++; $display("FAIL hs_j: got %0d want 8", m_j); end
    vec++;
    if (m_nb != 3) begin errs++; $display("FAIL hs_newbit: got %0d want 3", m_nb); end
    vec++;
    if (m_done != 1) begin errs++; $display("FAIL hs_done: got %0d want 1", m_done); end
    vec++;
    if (m_ovl != 0) begin errs++; $display("FAIL hs_tim_eop: got %0d want 0", m_ovl); end
    vec++;
    if (m_busy != 2 + 3 * 2 + 24) begin
      errs++; $display("FAIL hs_busy: got %0d want %0d", m_busy, 2 + 3 * 2 + 24);
    end
    vec++;
    if (m_first_eop - m_last_lb != 1) begin
      errs++; $display("FAIL hs_eop_gap: got %0d want 1", m_first_eop - m_last_lb);
    end
    vec++;
    if (idle !== 1'b1 || tx_busy !== 1'b0) begin
      errs++; $display("FAIL hs_back_idle: got %b%b want 10", idle, tx_busy);
    end
  endtask

  task automatic test_data();
    logic [1:0] exp_sel [6];
    exp_sel = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd3};
    run_packet(8'hC3, 1'b1, 7'd3, 1000, 1'b0);
    vec++;
    if (m_lb != 5 + CRC_LB) begin
      errs++; $display("FAIL d3_loads: got %0d want %0d", m_lb, 5 + CRC_LB);
    end
    for (int i = 0; i < 4 + CRC_LB; i++) begin
      vec++;
      if (lb_sel[i] !== exp_sel[i]) begin
        errs++; $display("FAIL d3_sel[%0d]: got %0d want %0d", i, lb_sel[i], exp_sel[i]);
      end
    end
    vec++;
    if (lb_byte[0] !== 8'hC3) begin errs++; $display("FAIL d3_pid: got %h want c3", lb_byte[0]); end
    vec++;
    if (m_pops != 3) begin errs++; $display("FAIL d3_fifo_rd: got %0d want 3", m_pops); end
    vec++;
    if (m_stray != 0) begin errs++; $display("FAIL d3_rd_align: got %0d want 0", m_stray); end
    vec++;
    if (m_eop != 16 || m_j != 8) begin
      errs++; $display("FAIL d3_eop: got %0d/%0d want 16/8", m_eop, m_j);
    end
    vec++;
    if (m_done != 1) begin errs++; $display("FAIL d3_done: got %0d want 1", m_done); end
    vec++;
    if (m_busy != 2 + 3 * (5 + CRC_LB) + 24) begin
      errs++; $display("FAIL d3_busy: got %0d want %0d", m_busy, 2 + 3 * (5 + CRC_LB) + 24);
    end
  endtask

  task automatic test_len_bounds();
    int hi;
    run_packet(8'hC3, 1'b1, 7'd0, 1000, 1'b0);
    vec++;
    if (m_lb != 2 + CRC_LB) begin
      errs++; $display("FAIL l0_loads: got %0d want %0d", m_lb, 2 + CRC_LB);
    end
    vec++;
    if (m_pops != 0) begin errs++; $display("FAIL l0_fifo_rd: got %0d want 0", m_pops); end
`ifdef USB_TX_CRC_EN
    vec++;
    if (lb_sel[1] !== 2'd2 || lb_sel[2] !== 2'd3) begin
      errs++; $display("FAIL l0_crc_sel: got %0d,%0d want 2,3", lb_sel[1], lb_sel[2]);
    end
`else
    hi = 0;
    foreach (lb_sel[i]) if (lb_sel[i] >= 2'd2) hi++;
    vec++;
    if (hi != 0) begin errs++; $display("FAIL l0_no_crc_sel: got %0d want 0", hi); end
`endif
    vec++;
    if (m_done != 1) begin errs++; $display("FAIL l0_done: got %0d want 1", m_done); end
    run_packet(8'h4B, 1'b1, 7'd100, 1000, 1'b0);
    vec++;
    if (m_pops != 64) begin errs++; $display("FAIL l100_fifo_rd: got %0d want 64", m_pops); end
    vec++;
    if (m_lb != 66 + CRC_LB) begin
      errs++; $display("FAIL l100_loads: got %0d want %0d", m_lb, 66 + CRC_LB);
    end
    vec++;
    if (m_done != 1 || m_timeout != 0) begin
      errs++; $display("FAIL l100_done: got %0d/%0d want 1/0", m_done, m_timeout);
    end
  endtask

  task automatic test_underrun();
    run_packet(8'hC3, 1'b1, 7'd4, 2, 1'b0);
    vec++;
    if (m_pops != 2) begin errs++; $display("FAIL ur_fifo_rd: got %0d want 2", m_pops); end
    vec++;
    if (m_lb != 4) begin errs++; $display("FAIL ur_loads: got %0d want 4", m_lb); end
    vec++;
    if (m_first_eop - m_last_lb != 1) begin
      errs++; $display("FAIL ur_eop_gap: got %0d want 1", m_first_eop - m_last_lb);
    end
    vec++;
    if (m_done != 1 || m_eop != 16) begin
      errs++; $display("FAIL ur_done: got %0d/%0d want 1/16", m_done, m_eop);
    end
    #1;
    vec++;
    if (tx_underrun !== 1'b1) begin errs++; $display("FAIL ur_flag: got %b want 1", tx_underrun); end
    step();
    #1;
    vec++;
    if (tx_underrun !== 1'b1) begin errs++; $display("FAIL ur_sticky: got %b want 1", tx_underrun); end
    run_packet(8'hD2, 1'b0, 7'd0, 1000, 1'b0);
    vec++;
    if (m_urun_start != 0) begin errs++; $display("FAIL ur_clear: got %0d want 0", m_urun_start); end
  endtask

  task automatic test_back_to_back();
    run_packet(8'h5A, 1'b0, 7'd0, 1000, 1'b1);
    vec++;
    if (m_ld != 1 || m_done != 1) begin
      errs++; $display("FAIL b2b_one_pkt: got %0d/%0d want 1/1", m_ld, m_done);
    end
    #1;
    vec++;
    if (idle !== 1'b1 || tx_busy !== 1'b0 || load_en !== 1'b0) begin
      errs++; $display("FAIL b2b_idle: got %b%b%b want 100", idle, tx_busy, load_en);
    end
    step();
    #1;
    vec++;
    if (load_en !== 1'b1 || tx_busy !== 1'b1 || FSM_byte !== 8'h80) begin
      errs++; $display("FAIL b2b_start: got %b%b %h want 11 80", load_en, tx_busy, FSM_byte);
    end
    tx_start = 1'b0;
    n_rst = 1'b0;
    #1;
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_mid_reset();
    int lbs, ph, bad;
    tx_pid = 8'hC3;
    tx_has_data = 1'b1;
    tx_len = 7'd10;
    fifo_empty = 1'b0;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    lbs = 0;
    ph = 0;
    for (int c = 0; c < 200 && lbs < 4; c++) begin
      Load_Byte = Tim_en && (ph == 2);
      #1;
      if (Load_Byte) lbs++;
      ph = Tim_en ? ((ph == 2) ? 0 : ph + 1) : 0;
      step();
    end
    Load_Byte = 1'b0;
    #1;
    vec++;
    if (lbs != 4 || Tim_en !== 1'b1) begin
      errs++; $display("FAIL mr_in_data: got %0d/%b want 4/1", lbs, Tim_en);
    end
    n_rst = 1'b0;
    #1;
    vec++;
    if ({idle, tx_busy, Tim_en} !== 3'b100) begin
      errs++; $display("FAIL mr_async: got %b want 100", {idle, tx_busy, Tim_en});
    end
    step();
    n_rst = 1'b1;
    #1;
    vec++;
    if ({idle, tx_busy, Tim_en, tx_done, eop} !== 5'b10000) begin
      errs++; $display("FAIL mr_after: got %b want 10000", {idle, tx_busy, Tim_en, tx_done, eop});
    end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      #1;
      if (tx_done || eop || tx_busy) bad++;
    end
    vec++;
    if (bad != 0) begin errs++; $display("FAIL mr_quiet: got %0d want 0", bad); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_handshake();
    test_data();
    test_len_bounds();
    test_underrun();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Packet-level controller for the USB byte transmitter datapath: byte register, bit timer, bit stuffer and NRZI encoder. On a transmit request it drives select/load_en/FSM_byte so the datapath sends SYNC, PID, optional FIFO payload and CRC16 in order. It then generates the EOP (2 SE0 bit times + 1 J bit time) with its own bit-time divider and returns the line to idle. It sits between the protocol FSM/FIFO and the transmitter, and is the only block allowed to drive the transmitter's control inputs.

## Interface
- No parameters. Bit time fixed at 8 clk cycles; max payload 64 bytes.
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- tx_start  in  1  request; sampled only in IDLE
- tx_pid  in  8  PID byte, captured on accepted tx_start
- tx_has_data  in  1  1 = data packet (payload+CRC), 0 = handshake (PID only); captured with tx_pid
- tx_len  in  7  payload bytes 0..64, captured with tx_pid; values >64 clamp to 64
- fifo_empty  in  1  TX FIFO empty
- Load_Byte  in  1  transmitter byte-complete pulse (register reloads this cycle)
- FSM_byte  out  8  byte presented when select=1
- select  out  2  0 = FIFO byte, 1 = FSM_byte, 2 = CRC low byte, 3 = CRC high byte
- load_en  out  1  forced register load
- idle  out  1  encoder idle (J)
- Tim_rst  out  1  timer sync reset
- Tim_en  out  1  timer enable
- eop  out  1  encoder SE0 drive
- eop_new_bit  out  1  encoder bit strobe during EOP
- fifo_rd  out  1  pop FIFO head
- tx_busy  out  1  packet in progress
- tx_done  out  1  one-cycle completion pulse
- tx_underrun  out  1  sticky; set on FIFO underrun, cleared by next accepted tx_start

## Operation
- States: IDLE, START, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J, DONE. Data states name the byte currently shifting; select/FSM_byte always name the byte loaded at the next Load_Byte.
- IDLE: idle=1, Tim_en=0. tx_start=1 → capture pid/has_data/len, clear tx_underrun → START.
- START (1 cycle): Tim_rst=1, load_en=1, select=1, FSM_byte=8'h80 (SYNC), idle=0 → SYNC. Tim_en=1 from SYNC through CRC_HI.
- SYNC: select=1, FSM_byte=tx_pid; Load_Byte → PID.
- PID: if has_data and len>0, select=0; if has_data and len=0, select=2; else don't-care. On Load_Byte: → DATA, CRC_LO, or EOP_SE0 respectively.
- DATA: 7-bit remaining counter loaded with len, decremented on every Load_Byte in DATA.
  - fifo_rd = Load_Byte (combinational) in PID/DATA while select=0.
  - On the last byte's Load_Byte: select→2 and state → CRC_LO.
  - Underrun: Load_Byte with select=0 and fifo_empty=1 → no fifo_rd, tx_underrun=1, abort to EOP_SE0.
- CRC_LO: select=3; Load_Byte → CRC_HI. CRC_HI: Load_Byte → EOP_SE0.
- EOP_SE0: Tim_en=0, eop=1. 3-bit divider counts clk; eop_new_bit pulses on every 8th cycle. After 2 pulses → EOP_J.
- EOP_J: eop=0, idle=0, one bit time (8 cycles, eop_new_bit pulse on 8th) → DONE.
- DONE (1 cycle): idle=1, Tim_rst=1, tx_done=1 → IDLE.

## Timing
- Reset (async): state IDLE; idle=1; all other outputs 0, including FSM_byte=0, select=0, tx_underrun=0. Mid-packet reset returns to IDLE immediately; no EOP is sent.
- tx_start → START one cycle later; tx_busy=1 from START through DONE inclusive.
- tx_start while busy: ignored. Asserted in the tx_done cycle: ignored. It is accepted in the following IDLE cycle.
- State advances on the clk edge that samples Load_Byte=1. select/FSM_byte are registered and stable for the whole cycle in which Load_Byte=1.
- EOP occupies exactly 24 cycles: 16 with eop=1, then 8 with J. Tim_en and eop are never both 1.
- Byte loaded at the Load_Byte that exits PID (handshake) or CRC_HI is ignored; eop overrides the encoder.

## Configuration
- USB_TX_CRC_EN defined: data packets append CRC_LO and CRC_HI as above.
- USB_TX_CRC_EN undefined: CRC states are removed; select never takes 2 or 3. Last payload byte (or PID when len=0) goes directly to EOP_SE0. Handshake packets are unchanged.

## Test plan
- Reset mid-DATA (n_rst low 1 cycle) → next cycle idle=1, tx_busy=0, Tim_en=0, no tx_done.
- Handshake tx_pid=8'hD2, has_data=0 → FSM_byte 8'h80 then 8'hD2; 2 Load_Byte pulses; 16 cycles eop=1, 8 J cycles; tx_done pulse; fifo_rd never asserted.
- Data tx_pid=8'hC3, len=3, FIFO non-empty → select sequence 1,1,0,0,0,2,3; exactly 3 fifo_rd pulses aligned with Load_Byte; tx_done after EOP.
- len=0, has_data=1 → PID then select=2,3 directly; zero fifo_rd. len=100 → exactly 64 fifo_rd.
- Underrun: len=4, fifo_empty rises after 2 pops → tx_underrun=1, 2 fifo_rd total, EOP_SE0 next, tx_done still pulses; next tx_start clears tx_underrun.
- tx_start held high continuously → exactly one packet per IDLE visit; a second START occurs 1 cycle after DONE.
